axis_sample_framer: RTL

AXIS_SAMPLE_FRAMER -- requirements
Module: axis_sample_framer

---
 rtl/framer_pkg.sv | 17 +
 rtl/sync_fifo.sv | 72 +++++++
 rtl/axis_sample_framer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/framer_pkg.sv
// Shared types and constants for the ADC sample framer: FSM encoding and
// statistics width, plus the saturating counter helper.
package framer_pkg;

    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } framer_state_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (&value) ? value : value + STAT_W'(1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered output stage; total capacity is DEPTH
// words (output register plus DEPTH-1 words in the backing memory).
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);

    localparam int            PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] MEM_MAX = (PTR_W + 1)'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   mem_cnt;

    logic pop;
    logic load_out;
    logic wr_ok;
    logic mem_rd;
    logic mem_wr;
    logic bypass;

    assign pop      = rd_valid & rd_ready;
    assign full     = rd_valid && (mem_cnt == MEM_MAX);
    assign empty    = ~rd_valid;
    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
    assign wr_ok    = wr_valid & (~full | pop);
    assign load_out = ~rd_valid | rd_ready;
    assign mem_rd   = load_out && (mem_cnt != '0);
    assign bypass   = load_out && (mem_cnt == '0) && wr_ok;
    assign mem_wr   = wr_ok & ~bypass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
            if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({mem_wr, mem_rd})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
            if (load_out) begin
                rd_valid <= mem_rd | bypass;
                if (mem_rd)      rd_data <= mem[rd_ptr];
                else if (bypass) rd_data <= wr_data;
            end
        end
    end

    // NOTE: storage has no reset; the pointers and count already make stale
    // contents unreachable, and a reset-free array maps onto RAM.
    always_ff @(posedge clk) begin
        if (mem_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/axis_sample_framer.sv
// Packs pairs of ADC samples into 2*DATA_W words, tags every FRAME_WORDS-th
// word with tlast and buffers them towards DMA, keeping drop/frame statistics.
module axis_sample_framer
    import framer_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int FRAME_WORDS = 256,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                axis_aclk,
    input  logic                axis_areset,
    input  logic                s_axis_tvalid,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    output logic                s_axis_tready,
    output logic                m_axis_tvalid,
    output logic [2*DATA_W-1:0] m_axis_tdata,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready,
    input  logic                enable,
    input  logic                clear_stats,
    output logic [STAT_W-1:0]   overflow_count,
    output logic [STAT_W-1:0]   frame_count,
    output logic                overflow_sticky,
    output logic                busy
);

    localparam int              WC_W     = $clog2(FRAME_WORDS);
    localparam logic [WC_W-1:0] LAST_IDX = WC_W'(FRAME_WORDS - 1);

    framer_state_t     state;
    framer_state_t     state_next;
    logic              phase;
    logic [DATA_W-1:0] low_half;
    logic [WC_W-1:0]   word_idx;

    logic              accept;
    logic              push;
    logic              word_last;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [2*DATA_W:0] fifo_wr_data;
    logic [2*DATA_W:0] fifo_rd_data;

    assign s_axis_tready = 1'b1;
    assign accept        = s_axis_tvalid && (state != ST_IDLE);
    assign push          = accept && phase;
    assign word_last     = (word_idx == LAST_IDX);
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign drop          = push & fifo_full & ~pop;
    assign fifo_wr_data  = {word_last, s_axis_tdata, low_half};

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) state <= ST_IDLE;
        else             state <= state_next;
    end

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (enable) state_next = ST_RUN;
            ST_RUN:    if (!enable) state_next = (word_idx != '0) ? ST_FINISH : ST_IDLE;
            ST_FINISH: if (push && word_last) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Dropped words still advance the index so frame boundaries stay aligned
    // to the sample stream; returning to IDLE discards any unpaired half.
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            phase    <= 1'b0;
            low_half <= '0;
            word_idx <= '0;
        end else if (state_next == ST_IDLE) begin
            phase    <= 1'b0;
            word_idx <= '0;
        end else begin
            if (accept) phase <= ~phase;
            if (accept && !phase) low_half <= s_axis_tdata;
            if (push) word_idx <= word_last ? '0 : word_idx + 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (2 * DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (axis_aclk),
        .rst      (axis_areset),
        .wr_valid (push),
        .wr_data  (fifo_wr_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .rd_ready (m_axis_tready),
        .rd_valid (m_axis_tvalid),
        .rd_data  (fifo_rd_data)
    );

    assign {m_axis_tlast, m_axis_tdata} = fifo_rd_data;

    // A clear in the same cycle as an overflow or frame event wins.
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            overflow_count  <= '0;
            frame_count     <= '0;
            overflow_sticky <= 1'b0;
        end else if (clear_stats) begin
            overflow_count  <= '0;
            frame_count     <= '0;
            overflow_sticky <= 1'b0;
        end else begin
            if (drop) begin
                overflow_count  <= sat_inc(overflow_count);
                overflow_sticky <= 1'b1;
            end
            if (pop && m_axis_tlast) frame_count <= frame_count + 1'b1;
        end
    end

    assign busy = (state != ST_IDLE) || !fifo_empty;

endmodule
